dt_res_packer: RTL and testbench

// - Read-back engine for the distance-transform result memory: scans the 128x128 8-bit res RAM in raster order,

---
 rtl/dt_pkg.sv | 18 +
 rtl/dt_bit_packer.sv | 40 ++++
 rtl/dt_res_packer.sv | 96 +++++++++
 tb/tb_dt_res_packer.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/dt_pkg.sv
// Shared sizes and FSM state encoding for the distance-transform result packer.
package dt_pkg;

  localparam int unsigned IMG_W   = 128;
  localparam int unsigned IMG_H   = 128;
  localparam int unsigned PIX_W   = 8;
  localparam int unsigned WORD_W  = 16;
  localparam int unsigned RES_AW  = $clog2(IMG_W * IMG_H);
  localparam int unsigned CNT_W   = $clog2(WORD_W);
  localparam int unsigned PK_AW   = RES_AW - CNT_W;
  localparam int unsigned FG_W    = RES_AW + 1;

  localparam logic [RES_AW-1:0] LAST_ADDR = RES_AW'(IMG_W * IMG_H - 1);
  localparam logic [PK_AW-1:0]  LAST_WORD = PK_AW'(IMG_W * IMG_H / WORD_W - 1);

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, FIN} state_t;

endpackage

// File: rtl/dt_bit_packer.sv
// Collects a serial stream of pixel bits MSB-first into WORD_W-bit words.
module dt_bit_packer
  import dt_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              valid,
  input  logic              pix_bit,
  output logic [WORD_W-1:0] word,
  output logic              word_valid
);

  logic [WORD_W-1:0] sr;
  logic [CNT_W-1:0]  cnt;

  // Word is published on the edge that consumes its last pixel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr         <= '0;
      cnt        <= '0;
      word       <= '0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= 1'b0;
      if (clr) begin
        sr  <= '0;
        cnt <= '0;
      end else if (valid) begin
        sr  <= {sr[WORD_W-2:0], pix_bit};
        cnt <= cnt + 1'b1;
        if (cnt == CNT_W'(WORD_W - 1)) begin
          word       <= {sr[WORD_W-2:0], pix_bit};
          word_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/dt_res_packer.sv
// Scans the res RAM in raster order, thresholds each distance and writes packed
// binary words, counting foreground pixels along the way.
module dt_res_packer
  import dt_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [PIX_W-1:0]  thr,
  output logic              busy,
  output logic              done,
  output logic              res_rd,
  output logic [RES_AW-1:0] res_addr,
  input  logic [PIX_W-1:0]  res_di,
  output logic              pk_wr,
  output logic [PK_AW-1:0]  pk_addr,
  output logic [WORD_W-1:0] pk_do,
  output logic [FG_W-1:0]   fg_cnt
);

  state_t            state;
  logic [PIX_W-1:0]  thr_q;
  logic              rd_vld;
  logic [RES_AW-1:0] rd_addr_q;
  logic              pix_bit_c;
  logic              start_ok_c;

  assign pix_bit_c  = res_di > thr_q;
  assign start_ok_c = start && ((state == IDLE) || (state == FIN));

  dt_bit_packer u_packer (
    .clk        (clk),
    .rst        (reset),
    .clr        (start_ok_c),
    .valid      (rd_vld),
    .pix_bit    (pix_bit_c),
    .word       (pk_do),
    .word_valid (pk_wr)
  );

  // Control FSM, read address generator, read-valid pipe and foreground count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      res_rd    <= 1'b0;
      res_addr  <= '0;
      pk_addr   <= '0;
      fg_cnt    <= '0;
      thr_q     <= '0;
      rd_vld    <= 1'b0;
      rd_addr_q <= '0;
    end else begin
      rd_vld    <= res_rd;
      rd_addr_q <= res_addr;
      // Word address tracks the pixel that completes the word in the packer.
      if (rd_vld && (rd_addr_q[CNT_W-1:0] == CNT_W'(WORD_W - 1))) begin
        pk_addr <= rd_addr_q[RES_AW-1:CNT_W];
      end
      if (rd_vld && pix_bit_c) begin
        fg_cnt <= fg_cnt + 1'b1;
      end
      case (state)
        IDLE, FIN: begin
          if (start) begin
            thr_q    <= thr;
            fg_cnt   <= '0;
            done     <= 1'b0;
            busy     <= 1'b1;
            res_rd   <= 1'b1;
            res_addr <= '0;
            state    <= SCAN;
          end
        end
        SCAN: begin
          if (res_addr == LAST_ADDR) begin
            res_rd <= 1'b0;
            state  <= DRAIN;
          end else begin
            res_addr <= res_addr + 1'b1;
          end
        end
        DRAIN: begin
          if (pk_wr && (pk_addr == LAST_WORD)) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= FIN;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dt_res_packer.sv
// Scoreboard bench for dt_res_packer: frames are queued as expected words, a
// monitor checks every packed-word write as it appears.
module tb_dt_res_packer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  thr = 8'd0;
  logic        busy;
  logic        done;
  logic        res_rd;
  logic [13:0] res_addr;
  logic [7:0]  res_di = 8'd0;
  logic        pk_wr;
  logic [9:0]  pk_addr;
  logic [15:0] pk_do;
  logic [14:0] fg_cnt;

  logic [7:0]  mem [16384];
  logic [25:0] exp_q [$];
  logic [25:0] exp_e;
  int          checks = 0;
  int          passes = 0;
  int          wr_count = 0;

  dt_res_packer dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .thr      (thr),
    .busy     (busy),
    .done     (done),
    .res_rd   (res_rd),
    .res_addr (res_addr),
    .res_di   (res_di),
    .pk_wr    (pk_wr),
    .pk_addr  (pk_addr),
    .pk_do    (pk_do),
    .fg_cnt   (fg_cnt)
  );

  always #5 clk = ~clk;

  // Res RAM model with one cycle of read latency.
  always @(posedge clk) begin
    if (res_rd) res_di <= mem[res_addr];
  end

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act == req) passes++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, req, req, $time);
  endtask

  always @(negedge clk) begin
    if (!reset && pk_wr) begin
      wr_count++;
      if (exp_q.size() == 0) begin
        check("unexpected_pk_wr", 1, 0);
      end else begin
        exp_e = exp_q.pop_front();
        check("pk_addr", int'(pk_addr), int'(exp_e[25:16]));
        check("pk_do", int'(pk_do), int'(exp_e[15:0]));
      end
    end
  end

  task automatic fill(input int mode);
    for (int a = 0; a < 16384; a++) begin
      case (mode)
        0: mem[a] = 8'd0;
        1: mem[a] = a[0] ? 8'd3 : 8'd0;
        2: mem[a] = 8'(a);
        default: mem[a] = (a == 16383) ? 8'd1 : 8'd0;
      endcase
    end
  endtask

  // Hand-derived word contents for each test pattern.
  function automatic logic [15:0] exp_word(input int mode, input int k);
    case (mode)
      0: return 16'h0000;
      1: return 16'h5555;
      2: return ((k % 16) >= 8) ? 16'hFFFF : 16'h0000;
      default: return (k == 1023) ? 16'h0001 : 16'h0000;
    endcase
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_res_rd"}, int'(res_rd), 0);
    check({tag, "_res_addr"}, int'(res_addr), 0);
    check({tag, "_pk_wr"}, int'(pk_wr), 0);
    check({tag, "_pk_addr"}, int'(pk_addr), 0);
    check({tag, "_pk_do"}, int'(pk_do), 0);
    check({tag, "_fg_cnt"}, int'(fg_cnt), 0);
  endtask

  task automatic run_frame(input int mode, input logic [7:0] t, input int inj_cyc,
                           input int rst_cyc, input int exp_fg);
    int cyc;
    fill(mode);
    exp_q.delete();
    for (int k = 0; k < 1024; k++) exp_q.push_back({10'(k), exp_word(mode, k)});
    @(negedge clk);
    wr_count = 0;
    start = 1'b1;
    thr = t;
    @(negedge clk);
    start = 1'b0;
    thr = ~t;
    cyc = 1;
    check("first_busy", int'(busy), 1);
    check("first_res_rd", int'(res_rd), 1);
    check("first_res_addr", int'(res_addr), 0);
    check("first_done", int'(done), 0);
    while (!done && cyc < 20000) begin
      start = (cyc == inj_cyc);
      if (cyc == inj_cyc) thr = 8'd5;
      if (cyc == rst_cyc) begin
        reset = 1'b1;
        exp_q.delete();
        #1;
        check_reset_outputs("midreset");
        repeat (3) @(negedge clk);
        check_reset_outputs("midreset_hold");
        reset = 1'b0;
        repeat (40) @(negedge clk);
        check("words_before_reset", wr_count, 562);
        check("idle_after_reset_busy", int'(busy), 0);
        return;
      end
      @(negedge clk);
      cyc++;
      if (cyc == 16384) begin
        check("last_rd", int'(res_rd), 1);
        check("last_addr", int'(res_addr), 16383);
      end
      if (cyc == 16385) begin
        check("drain_rd", int'(res_rd), 0);
        check("drain_addr_hold", int'(res_addr), 16383);
      end
    end
    start = 1'b0;
    check("done_cycle", cyc, 16387);
    check("done_level", int'(done), 1);
    check("busy_at_done", int'(busy), 0);
    check("fg_cnt", int'(fg_cnt), exp_fg);
    check("word_count", wr_count, 1024);
    check("queue_empty", exp_q.size(), 0);
    repeat (5) @(negedge clk);
    check("done_held", int'(done), 1);
    check("fg_cnt_held", int'(fg_cnt), exp_fg);
  endtask

  initial begin
    fill(0);
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("idle");
    run_frame(0, 8'd0,   -1, -1, 0);
    run_frame(1, 8'd0,   500, -1, 8192);
    run_frame(2, 8'd127, -1, -1, 8192);
    run_frame(3, 8'd0,   -1, 9000, 1);
    run_frame(3, 8'd0,   -1, -1, 1);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
